// File: rtl/mc_chroma_ref_fetch.sv
// -----------------------------------------------------------------------------
// mc_chroma_ref_fetch
//
// Reads a chroma reference block out of a row-organised window SRAM and
// streams it, one row per beat, to a 2-pel-wide chroma interpolator.
//
// The block is cut into vertical strips two columns wide. Each strip is read
// top to bottom as H+1 rows, because the interpolator needs the row below the
// block as well. Every beat carries the three pixels at columns c, c+1 and
// c+2, which is all one 2-pel output pair needs horizontally. A two-cycle
// bubble separates strips, so the interpolator never pairs the last row of one
// strip with the first row of the next. end_oneblk_o marks each strip end.
//
// Per-block timeline, with start_i sampled in cycle 0 and P = H+3:
//   strip s reads     : cycles 1+s*P .. 1+s*P+H       (rd_en_o, rows ascending)
//   strip s beats     : cycles 3+s*P .. 3+s*P+H       (ref_valid_o)
//   strip s end pulse : cycle  4+s*P+H                (end_oneblk_o)
//   done_o            : cycle  (W/2)*P+1, together with the last end pulse
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   start_i                 one-cycle block request, sampled only in IDLE
//   blk_x_i, blk_y_i        block top-left position in the window
//   blk_w_i, blk_h_i        size codes: 0=2, 1=4, 2=8, 3=8
//   fracx_i, fracy_i        chroma MV fractions, latched with the request
//   rd_en_o, rd_addr_o      SRAM read strobe and row address
//   rd_data_i               SRAM row, returned one cycle after rd_en_o
//   ref_valid_o             beat valid toward the interpolator
//   refuv_p0/p1/p2_o        pixels at columns c, c+1, c+2 of the beat's row
//   end_oneblk_o            one-cycle strip-end pulse
//   fracx_o, fracy_o        fractions of the current or most recent block
//   busy_o, done_o          block in progress / one-cycle block-complete pulse
//   dbg_state_o             FSM state, for observation only
// -----------------------------------------------------------------------------
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module mc_chroma_ref_fetch (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [3:0]                blk_x_i,
  input  logic [4:0]                blk_y_i,
  input  logic [1:0]                blk_w_i,
  input  logic [1:0]                blk_h_i,
  input  logic [2:0]                fracx_i,
  input  logic [2:0]                fracy_i,
  output logic                      rd_en_o,
  output logic [4:0]                rd_addr_o,
  input  logic [16*`BIT_DEPTH-1:0]  rd_data_i,
  output logic                      ref_valid_o,
  output logic [`BIT_DEPTH-1:0]     refuv_p0_o,
  output logic [`BIT_DEPTH-1:0]     refuv_p1_o,
  output logic [`BIT_DEPTH-1:0]     refuv_p2_o,
  output logic                      end_oneblk_o,
  output logic [2:0]                fracx_o,
  output logic [2:0]                fracy_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                dbg_state_o
);

  localparam int BD = `BIT_DEPTH;

  // Handshake: start_i is a single-cycle request with no ready. It is
  // honoured only while the FSM is IDLE (busy_o low); any pulse while busy_o
  // is high is dropped. rd_en_o is a read strobe whose data is expected on
  // rd_data_i exactly one cycle later; the SRAM cannot stall. ref_valid_o is
  // a push-only valid: the consumer must take every beat it is presented.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Block parameters captured with the request.
  logic [3:0] x_q;
  logic [4:0] y_q;
  logic [3:0] h_q;        // block height in rows: 2, 4 or 8
  logic [1:0] nstr_m1_q;  // number of strips minus one: 0, 1 or 3

  // Position within the block.
  logic [3:0] cnt_q;      // row offset in FETCH, bubble cycle in GAP
  logic [1:0] strip_q;

  logic fetch_last;       // last read of the current strip
  logic final_strip;
  logic gap_last;         // last cycle of the bubble after a strip

  // Read-return pipeline: stage 1 lines up with rd_data_i, stage 2 is the
  // beat presented on ref_valid_o.
  logic       v1_q;
  logic       last1_q;
  logic       fin1_q;
  logic [3:0] col1_q;
  logic       last2_q;
  logic       fin2_q;

  logic [BD-1:0] row_pix [16];
  logic [3:0]    col_p1;
  logic [3:0]    col_p2;

  // ---------------------------------------------------------------------------
  // Size decode
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] size_rows(input logic [1:0] code);
    case (code)
      2'd0:    return 4'd2;
      2'd1:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [1:0] strips_m1(input logic [1:0] code);
    case (code)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // The bubble after a strip is two cycles. After the final strip it is three:
  // the extra cycle is the one in which the last end_oneblk_o / done_o leave
  // the pipeline, so busy_o covers them and IDLE starts the cycle after done_o.
  always_comb begin
    fetch_last  = (state_q == FETCH) && (cnt_q == h_q);
    final_strip = (strip_q == nstr_m1_q);
    gap_last    = (state_q == GAP) && (cnt_q == (final_strip ? 4'd2 : 4'd1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        if (fetch_last) state_d = GAP;
      end
      GAP: begin
        if (gap_last) state_d = final_strip ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_en_o     = 1'b0;
    rd_addr_o   = 5'd0;
    busy_o      = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      FETCH: begin
        rd_en_o   = 1'b1;
        rd_addr_o = y_q + {1'b0, cnt_q};
        busy_o    = 1'b1;
      end
      GAP: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Block parameters and position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_q       <= '0;
      y_q       <= '0;
      h_q       <= '0;
      nstr_m1_q <= '0;
      fracx_o   <= '0;
      fracy_o   <= '0;
      cnt_q     <= '0;
      strip_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q       <= blk_x_i;
            y_q       <= blk_y_i;
            h_q       <= size_rows(blk_h_i);
            nstr_m1_q <= strips_m1(blk_w_i);
            fracx_o   <= fracx_i;
            fracy_o   <= fracy_i;
            cnt_q     <= '0;
            strip_q   <= '0;
          end
        end
        FETCH: begin
          cnt_q <= fetch_last ? 4'd0 : cnt_q + 4'd1;
        end
        GAP: begin
          if (gap_last) begin
            cnt_q   <= '0;
            strip_q <= strip_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return pipeline
  // ---------------------------------------------------------------------------
  // The strip column travels with each read so the pixel select never depends
  // on strip_q, which may already have moved on by the time data returns.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      fin1_q  <= 1'b0;
      col1_q  <= '0;
    end else begin
      v1_q    <= rd_en_o;
      last1_q <= fetch_last;
      fin1_q  <= fetch_last && final_strip;
      col1_q  <= x_q + {1'b0, strip_q, 1'b0};
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_row_pix
    assign row_pix[k] = rd_data_i[BD*k +: BD];
  end

  assign col_p1 = col1_q + 4'd1;
  assign col_p2 = col1_q + 4'd2;

  // Pixels only load on a returning read, so they hold between beats.
  // Clearing v1_q on reset is what drops a read that was in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_valid_o <= 1'b0;
      refuv_p0_o  <= '0;
      refuv_p1_o  <= '0;
      refuv_p2_o  <= '0;
      last2_q     <= 1'b0;
      fin2_q      <= 1'b0;
    end else begin
      ref_valid_o <= v1_q;
      last2_q     <= v1_q && last1_q;
      fin2_q      <= v1_q && fin1_q;
      if (v1_q) begin
        refuv_p0_o <= row_pix[col1_q];
        refuv_p1_o <= row_pix[col_p1];
        refuv_p2_o <= row_pix[col_p2];
      end
    end
  end

  // Strip end follows the strip's last beat by one cycle; the final strip
  // end doubles as the block completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      end_oneblk_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      end_oneblk_o <= last2_q;
      done_o       <= fin2_q;
    end
  end

endmodule

// File: tb/tb_mc_chroma_ref_fetch.sv
// -----------------------------------------------------------------------------
// tb_mc_chroma_ref_fetch
//
// Directed bench for mc_chroma_ref_fetch. A behavioural SRAM returns row r
// with pixel k = (16*r + k) truncated to the pixel width. Expected schedules
// come from the block timeline (reads from cycle 1+s*(H+3), beats two cycles
// after each read, strip end one cycle after the last beat). The chained test
// adds a small 2-pel bilinear interpolator and compares it with a golden
// 1/8-pel model computed straight from the pixel formula.
// -----------------------------------------------------------------------------
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module tb_mc_chroma_ref_fetch;

  localparam int BD = `BIT_DEPTH;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        blk_x;
  logic [4:0]        blk_y;
  logic [1:0]        blk_w;
  logic [1:0]        blk_h;
  logic [2:0]        fracx;
  logic [2:0]        fracy;
  logic              rd_en;
  logic [4:0]        rd_addr;
  logic [16*BD-1:0]  rd_data;
  logic              ref_valid;
  logic [BD-1:0]     p0;
  logic [BD-1:0]     p1;
  logic [BD-1:0]     p2;
  logic              end_oneblk;
  logic [2:0]        fracx_q;
  logic [2:0]        fracy_q;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_chroma_ref_fetch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .blk_x_i      (blk_x),
    .blk_y_i      (blk_y),
    .blk_w_i      (blk_w),
    .blk_h_i      (blk_h),
    .fracx_i      (fracx),
    .fracy_i      (fracy),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .ref_valid_o  (ref_valid),
    .refuv_p0_o   (p0),
    .refuv_p1_o   (p1),
    .refuv_p2_o   (p2),
    .end_oneblk_o (end_oneblk),
    .fracx_o      (fracx_q),
    .fracy_o      (fracy_q),
    .busy_o       (busy),
    .done_o       (done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference SRAM model and expectation state
  // ---------------------------------------------------------------------------
  function automatic logic [BD-1:0] pix(input int r, input int k);
    return BD'(16 * r + k);
  endfunction

  function automatic int size_of(input int code);
    return (code == 0) ? 2 : (code == 1) ? 4 : 8;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      for (int k = 0; k < 16; k++) rd_data[BD*k +: BD] <= pix(int'(rd_addr), k);
    end
  end

  int total;
  int bad;
  logic [2:0]    last_fx;
  logic [2:0]    last_fy;
  logic [BD-1:0] last_p0;
  logic [BD-1:0] last_p1;
  logic [BD-1:0] last_p2;
  logic [7:0]    exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    blk_x = '0; blk_y = '0; blk_w = '0; blk_h = '0;
    fracx = '0; fracy = '0;
    last_fx = '0; last_fy = '0;
    last_p0 = '0; last_p1 = '0; last_p2 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_en, rd_addr, ref_valid, p0, p1, p2, end_oneblk, fracx_q, fracy_q, busy, done, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_hold: rd_en=%b addr=%0d valid=%b p=%0d,%0d,%0d end=%b fx=%0d fy=%0d busy=%b done=%b st=%0d, want all 0",
               rd_en, rd_addr, ref_valid, p0, p1, p2, end_oneblk, fracx_q, fracy_q, busy, done, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rd_en, ref_valid, end_oneblk, busy, done, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_release: rd_en=%b valid=%b end=%b busy=%b done=%b st=%0d, want all 0",
               rd_en, ref_valid, end_oneblk, busy, done, dbg_state);
    end
  endtask

  // Quiet cycles: nothing moves, pixels and fractions hold.
  task automatic test_idle(input string name, input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      total++;
      if ({rd_en, ref_valid, end_oneblk, done, busy, dbg_state} !== '0) begin
        bad++;
        $display("FAIL %s_quiet c%0d: rd_en=%b valid=%b end=%b done=%b busy=%b st=%0d, want all 0",
                 name, t, rd_en, ref_valid, end_oneblk, done, busy, dbg_state);
      end
      total++;
      if ({p0, p1, p2, fracx_q, fracy_q} !== {last_p0, last_p1, last_p2, last_fx, last_fy}) begin
        bad++;
        $display("FAIL %s_hold c%0d: p=%0d,%0d,%0d fx=%0d fy=%0d, want p=%0d,%0d,%0d fx=%0d fy=%0d",
                 name, t, p0, p1, p2, fracx_q, fracy_q, last_p0, last_p1, last_p2, last_fx, last_fy);
      end
    end
  endtask

  // One block, checked every cycle from cycle 0 to done_o. The caller's next
  // task samples the cycle after done_o, which may itself be a new start.
  task automatic test_block(input string name, input int x, input int y, input int wc,
                            input int hc, input int fx, input int fy, input bit repulse);
    int w, h, p, nstr, dur, s, j;
    bit e_rd, e_v, e_end, e_done, e_busy;
    w = size_of(wc); h = size_of(hc); p = h + 3; nstr = w / 2; dur = nstr * p + 1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || fracx_q !== last_fx || fracy_q !== last_fy) begin
      bad++;
      $display("FAIL %s_c0: busy=%b st=%0d fx=%0d fy=%0d, want busy=0 st=0 fx=%0d fy=%0d",
               name, busy, dbg_state, fracx_q, fracy_q, last_fx, last_fy);
    end
    blk_x = 4'(x); blk_y = 5'(y); blk_w = 2'(wc); blk_h = 2'(hc);
    fracx = 3'(fx); fracy = 3'(fy);
    start = 1'b1;
    for (int t = 1; t <= dur; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (repulse && (t == 2 || t == 5)) begin
        start = 1'b1;
        blk_x = '0; blk_y = '0; blk_w = 2'd0; blk_h = 2'd0;
        fracx = 3'(7 - fx); fracy = 3'(7 - fy);
      end
      if (t == 1) begin
        last_fx = 3'(fx);
        last_fy = 3'(fy);
      end
      s = (t - 1) / p;
      j = (t - 1) % p;
      e_rd   = (s < nstr) && (j <= h);
      e_v    = (s < nstr) && (j >= 2) && (j <= h + 2);
      e_end  = (t > 1) && (j == 0);
      e_done = (t == dur);
      e_busy = 1'b1;
      if (e_v) begin
        last_p0 = pix(y + j - 2, x + 2 * s);
        last_p1 = pix(y + j - 2, x + 2 * s + 1);
        last_p2 = pix(y + j - 2, x + 2 * s + 2);
      end
      total++;
      if ({rd_en, ref_valid, end_oneblk, done, busy} !== {e_rd, e_v, e_end, e_done, e_busy}) begin
        bad++;
        $display("FAIL %s_ctl c%0d: rd_en=%b valid=%b end=%b done=%b busy=%b, want %b %b %b %b %b",
                 name, t, rd_en, ref_valid, end_oneblk, done, busy, e_rd, e_v, e_end, e_done, e_busy);
      end
      if (e_rd) begin
        total++;
        if (rd_addr !== 5'(y + j)) begin
          bad++;
          $display("FAIL %s_addr c%0d: addr=%0d, want %0d", name, t, rd_addr, y + j);
        end
      end
      total++;
      if ({p0, p1, p2} !== {last_p0, last_p1, last_p2}) begin
        bad++;
        $display("FAIL %s_pix c%0d: p=%0d,%0d,%0d, want %0d,%0d,%0d",
                 name, t, p0, p1, p2, last_p0, last_p1, last_p2);
      end
      total++;
      if (fracx_q !== last_fx || fracy_q !== last_fy) begin
        bad++;
        $display("FAIL %s_frac c%0d: fx=%0d fy=%0d, want fx=%0d fy=%0d",
                 name, t, fracx_q, fracy_q, last_fx, last_fy);
      end
    end
    start = 1'b0;
  endtask

  // Reset asserted in cycle 3 of a W=4,H=2 block, with reads in flight.
  task automatic test_reset_mid;
    @(negedge clk);
    blk_x = 4'd2; blk_y = 5'd6; blk_w = 2'd1; blk_h = 2'd0;
    fracx = 3'd6; fracy = 3'd1;
    start = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (rd_en !== 1'b1 || busy !== 1'b1 || rd_addr !== 5'(6 + t - 1)) begin
        bad++;
        $display("FAIL rst_mid_pre c%0d: rd_en=%b busy=%b addr=%0d, want 1 1 %0d",
                 t, rd_en, busy, rd_addr, 6 + t - 1);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_en, rd_addr, ref_valid, p0, p1, p2, end_oneblk, fracx_q, fracy_q, busy, done, dbg_state} !== '0) begin
      bad++;
      $display("FAIL rst_mid_clear: rd_en=%b addr=%0d valid=%b p=%0d,%0d,%0d end=%b fx=%0d fy=%0d busy=%b done=%b st=%0d, want all 0",
               rd_en, rd_addr, ref_valid, p0, p1, p2, end_oneblk, fracx_q, fracy_q, busy, done, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_fx = '0; last_fy = '0;
    last_p0 = '0; last_p1 = '0; last_p2 = '0;
    test_idle("rst_mid_after", 8);
  endtask

  // Fetch chained into a 2-pel bilinear interpolator driven by the fetch's
  // own beats, strip ends and latched fractions.
  task automatic test_interp;
    int x, y, h, cyc;
    int a, b, c, d, fx, fy, val;
    bit have;
    logic [BD-1:0] q0, q1, q2;
    logic [7:0] got, want;
    x = 3; y = 5; h = 4; fx = 3; fy = 5;
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < h; r++) begin
        for (int k = 0; k < 2; k++) begin
          a = int'(pix(y + r,     x + 2 * s + k));
          b = int'(pix(y + r,     x + 2 * s + k + 1));
          c = int'(pix(y + r + 1, x + 2 * s + k));
          d = int'(pix(y + r + 1, x + 2 * s + k + 1));
          val = ((8 - fx) * (8 - fy) * a + fx * (8 - fy) * b + (8 - fx) * fy * c + fx * fy * d + 32) >> 6;
          exp_q.push_back(8'(val));
        end
      end
    end
    @(negedge clk);
    blk_x = 4'(x); blk_y = 5'(y); blk_w = 2'd1; blk_h = 2'd1;
    fracx = 3'(fx); fracy = 3'(fy);
    start = 1'b1;
    have = 1'b0;
    q0 = '0; q1 = '0; q2 = '0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (ref_valid) begin
        if (have) begin
          for (int k = 0; k < 2; k++) begin
            a = int'(k == 0 ? q0 : q1);
            b = int'(k == 0 ? q1 : q2);
            c = int'(k == 0 ? p0 : p1);
            d = int'(k == 0 ? p1 : p2);
            val = ((8 - int'(fracx_q)) * (8 - int'(fracy_q)) * a + int'(fracx_q) * (8 - int'(fracy_q)) * b
                   + (8 - int'(fracx_q)) * int'(fracy_q) * c + int'(fracx_q) * int'(fracy_q) * d + 32) >> 6;
            got = 8'(val);
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL interp_extra c%0d: output %0d, want none", cyc, got);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                bad++;
                $display("FAIL interp_pel c%0d k%0d: got %0d, want %0d", cyc, k, got, want);
              end
            end
          end
        end
        q0 = p0; q1 = p1; q2 = p2;
        have = 1'b1;
      end
      if (end_oneblk) have = 1'b0;
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL interp_timeout: no done after %0d cycles, want done", cyc);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL interp_count: %0d outputs missing, want 0", exp_q.size());
    end
    last_fx = 3'(fx); last_fy = 3'(fy);
    last_p0 = pix(y + h, x + 2);
    last_p1 = pix(y + h, x + 3);
    last_p2 = pix(y + h, x + 4);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    // W=2,H=2 at the origin, zero fractions: rows 0..2, beats (0,1,2) (16,17,18) (32,33,34).
    test_block("basic", 0, 0, 0, 0, 0, 0, 1'b0);
    test_idle("basic", 3);
    // W=8,H=8 at x=7,y=23: columns 7,9,11,13, done at cycle 45.
    test_block("big", 7, 23, 3, 2, 5, 2, 1'b0);
    test_idle("big", 3);
    // W=4,H=4 with start re-pulsed at cycles 2 and 5.
    test_block("restart", 2, 4, 1, 1, 1, 7, 1'b1);
    test_idle("restart", 4);
    test_reset_mid();
    test_block("after_rst", 2, 6, 1, 0, 6, 1, 1'b0);
    test_idle("after_rst", 2);
    // Back to back: second start in the cycle after the first done.
    test_block("b2b_a", 1, 10, 0, 1, 2, 3, 1'b0);
    test_block("b2b_b", 4, 0, 1, 0, 7, 4, 1'b0);
    test_idle("b2b", 3);
    test_interp();
    test_idle("interp", 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_chroma_ref_fetch.md
MC_CHROMA_REF_FETCH -- requirements
Module: mc_chroma_ref_fetch

Interface
REQ-001 SHALL have port: clk_i  input  1  clock, all state on rising edge.
REQ-002 SHALL have port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start_i  input  1  one-cycle block request, sampled only in IDLE.
REQ-004 SHALL have port: blk_x_i  input  4  block left column in window; precondition blk_x_i+W <= 15.
REQ-005 SHALL have port: blk_y_i  input  5  block top row in window; precondition blk_y_i+H <= 31.
REQ-006 SHALL have port: blk_w_i, blk_h_i  input  2 each  size code: 0=2, 1=4, 2=8, 3=8 (gives W, H).
REQ-007 SHALL have port: fracx_i, fracy_i  input  3 each  chroma MV fraction.
REQ-008 SHALL have port: rd_en_o  output  1  reference SRAM read strobe.
REQ-009 SHALL have port: rd_addr_o  output  5  SRAM row address.
REQ-010 SHALL have port: rd_data_i  input  16*`BIT_DEPTH  one row, 1-cycle latency; pixel k at bits [`BIT_DEPTH*k+`BIT_DEPTH-1 : `BIT_DEPTH*k].
REQ-011 SHALL have port: ref_valid_o  output  1  beat valid for the 2-pel chroma interpolator.
REQ-012 SHALL have port: refuv_p0_o, refuv_p1_o, refuv_p2_o  output  `BIT_DEPTH each  pixels at columns c, c+1, c+2.
REQ-013 SHALL have port: end_oneblk_o  output  1  one-cycle strip-end pulse.
REQ-014 SHALL have port: fracx_o, fracy_o  output  3 each  latched fractions.
REQ-015 SHALL have port: busy_o, done_o  output  1 each  status; done_o is a one-cycle pulse.

Function
REQ-016 SHALL implement FSM IDLE -> FETCH -> GAP -> (FETCH | IDLE).
REQ-017 SHALL, in IDLE on start_i=1, latch blk_x/y, W, H, fracx/fracy; start_i during FETCH/GAP ignored.
REQ-018 SHALL split the block into W/2 strips; strip s uses column c = blk_x + 2s.
REQ-019 SHALL, per strip, issue H+1 reads on consecutive cycles, rows blk_y..blk_y+H in ascending order.
REQ-020 SHALL time strip s reads from cycle 1+s*(H+3); start_i sampled in cycle 0.
REQ-021 SHALL assert ref_valid_o exactly 2 cycles after each rd_en_o, with p0/p1/p2 registered from pixels c, c+1, c+2 of that row.
REQ-022 SHALL pulse end_oneblk_o the cycle after the last ref_valid_o of each strip.
REQ-023 SHALL hold ref_valid_o low during the end_oneblk_o cycle and the following cycle; next strip's first beat is 2 cycles after end_oneblk_o.
REQ-024 SHALL hold fracx_o/fracy_o stable from cycle 1 until the next accepted start_i.
REQ-025 SHALL hold busy_o high from cycle 1 through the final end_oneblk_o cycle inclusive.
REQ-026 SHALL pulse done_o coincident with the final end_oneblk_o; FSM enters IDLE the cycle after.
REQ-027 SHALL allow start_i in the cycle after done_o to be accepted.
REQ-028 SHALL apply the identical schedule when fracx=fracy=0; no bypass path.
REQ-029 SHALL hold refuv_p*_o at last values when ref_valid_o=0.
REQ-030 SHALL give total block duration (W/2)*(H+3)+1 cycles from start_i to done_o.

Reset
REQ-031 SHALL, on rst_n_i=0, immediately clear all outputs to 0 and the FSM to IDLE, at any point including mid-strip.
REQ-032 SHALL discard in-flight read data after reset; no ref_valid_o until a new start_i.

Verification
REQ-033 SHALL cover: W=2,H=2, x=0,y=0, row r pixel k = 16r+k -> reads rows 0,1,2 at cycles 1-3; valid cycles 3-5 with (p0,p1,p2)=(0,1,2),(16,17,18),(32,33,34); end_oneblk_o+done_o at cycle 6.
REQ-034 SHALL cover: W=8,H=8, x=7,y=23 -> 4 strips, columns 7,9,11,13; 9 beats each; strip reads at cycles 1,12,23,34; done_o at cycle 45.
REQ-035 SHALL cover: start_i re-pulsed at cycles 2 and 5 during W=4,H=4 -> ignored; latched fracx_o unchanged; single done_o at cycle 15.
REQ-036 SHALL cover: rst_n_i low at cycle 3 of W=4,H=2 -> all outputs 0 next sample; no further ref_valid_o; a new start_i gives the full schedule from cycle 1.
REQ-037 SHALL cover: back-to-back blocks, start_i the cycle after done_o -> accepted; fracx_o/fracy_o switch at that block's cycle 1.
REQ-038 SHALL cover: chained with the 2-pel chroma interpolator, fracx=3,fracy=5 -> interpolated output matches the golden 1/8-pel bilinear model for every strip, with no cross-strip pair emitted.
